// File: rtl/fifo_rd_stream_adapter_if.sv
// Read-stream bundle between the FIFO read port, the adapter and the host.
// The master modport is the adapter side; slave is the FIFO/host environment.
interface fifo_rd_stream_adapter_if #(
    parameter int DATA_W     = 16,
    parameter int SKID_DEPTH = 2
);
    localparam int OCC_W = $clog2(SKID_DEPTH) + 1;

    logic              mem_ren;
    logic [DATA_W-1:0] mem_data;
    logic              mem_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [OCC_W-1:0]  occupancy;
    logic              resp_err;

    modport master (
        output mem_ren, out_data, out_valid, occupancy, resp_err,
        input  mem_data, mem_valid, out_ready
    );

    modport slave (
        input  mem_ren, out_data, out_valid, occupancy, resp_err,
        output mem_data, mem_valid, out_ready
    );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Turns the FIFO's 1-cycle-latency read port into a zero-bubble valid/ready
// stream using a small skid buffer, and flags stray or overflowing responses.
module fifo_rd_stream_adapter #(
    parameter int DATA_W     = 16,
    parameter int SKID_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    fifo_rd_stream_adapter_if.master  bus
);
    localparam int PTR_W = $clog2(SKID_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_C  = OCC_W'(SKID_DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [OCC_W-1:0]  count_q, count_d;
    logic              inflight_q, inflight_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] entry_q [SKID_DEPTH];
    logic [DATA_W-1:0] entry_d [SKID_DEPTH];

    logic              out_valid_s;
    logic              pop_s;
    logic              push_s;
    logic              stray_s;
    logic              overflow_s;
    logic              write_s;
    logic              mem_ren_s;
    logic [OCC_W:0]    credit_s;

    // Handshake qualifiers and request credit for the current cycle
    always_comb begin
        out_valid_s = clk_en && (count_q != {OCC_W{1'b0}});
        pop_s       = out_valid_s && bus.out_ready;
        push_s      = clk_en && inflight_q && bus.mem_valid;
        stray_s     = clk_en && !inflight_q && bus.mem_valid;
        overflow_s  = push_s && (count_q == FULL_C) && !pop_s;
        write_s     = push_s && !overflow_s;
        // Counting the in-flight word and the word leaving now lets a full
        // buffer still request when the host drains it in the same cycle.
        credit_s    = {1'b0, count_q} + {{OCC_W{1'b0}}, inflight_q}
                    - {{OCC_W{1'b0}}, pop_s};
        mem_ren_s   = clk_en && !rst && (credit_s < {1'b0, FULL_C});
    end

    // Next-state for counters, pointers, error flag and skid entries
    always_comb begin
        count_d    = count_q;
        inflight_d = inflight_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        resp_err_d = resp_err_q;
        for (int i = 0; i < SKID_DEPTH; i++) begin
            entry_d[i] = entry_q[i];
        end
        if (clk_en) begin
            inflight_d = mem_ren_s;
            resp_err_d = resp_err_q | stray_s | overflow_s;
            if (write_s && !pop_s) begin
                count_d = count_q + OCC_ONE;
            end else if (!write_s && pop_s) begin
                count_d = count_q - OCC_ONE;
            end else begin
                count_d = count_q;
            end
            if (write_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                for (int i = 0; i < SKID_DEPTH; i++) begin
                    if (wr_ptr_q == PTR_W'(i)) begin
                        entry_d[i] = bus.mem_data;
                    end else begin
                        entry_d[i] = entry_q[i];
                    end
                end
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= {OCC_W{1'b0}};
            inflight_q <= 1'b0;
            rd_ptr_q   <= {PTR_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            resp_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            resp_err_q <= resp_err_d;
        end
    end

    // Skid data storage; contents are meaningless while count is zero
    always_ff @(posedge clk) begin
        for (int i = 0; i < SKID_DEPTH; i++) begin
            entry_q[i] <= entry_d[i];
        end
    end

    assign bus.mem_ren   = mem_ren_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = entry_q[rd_ptr_q];
    assign bus.occupancy = count_q;
    assign bus.resp_err  = resp_err_q;
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter: a queue stands in for the FIFO
// (1-cycle registered read response, frozen with clk_en).
module tb_fifo_rd_stream_adapter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_en = 1'b0;

    fifo_rd_stream_adapter_if #(.DATA_W(16), .SKID_DEPTH(2)) bus_if ();

    fifo_rd_stream_adapter #(.DATA_W(16), .SKID_DEPTH(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          xfers = 0;
    int          ren_cnt;
    logic [15:0] exp_word = 16'h0000;
    logic [15:0] q [$];
    logic        fv = 1'b0;
    logic [15:0] fd = 16'h0000;
    logic        force_v = 1'b0;
    logic [15:0] force_d = 16'h0000;
    logic        s_ren, s_valid, s_err;
    logic [15:0] s_data;
    logic [1:0]  s_occ;
    logic [1:0]  occ_held;
    logic        prev_en0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs at negedge, sample outputs, advance FIFO model.
    task automatic step(input logic en, input logic rdy, input logic r);
        @(negedge clk);
        rst = r;
        clk_en = en;
        bus_if.out_ready = rdy;
        if (force_v) begin
            bus_if.mem_valid = 1'b1;
            bus_if.mem_data  = force_d;
            force_v = 1'b0;
        end else begin
            bus_if.mem_valid = fv;
            bus_if.mem_data  = fd;
        end
        #1;
        s_ren   = bus_if.mem_ren;
        s_valid = bus_if.out_valid;
        s_data  = bus_if.out_data;
        s_occ   = bus_if.occupancy;
        s_err   = bus_if.resp_err;
        if (!en) begin
            check("en0_out_valid", {31'd0, s_valid}, 32'd0);
            check("en0_mem_ren", {31'd0, s_ren}, 32'd0);
        end
        if (r) begin
            check("rst_mem_ren", {31'd0, s_ren}, 32'd0);
        end
        if (s_valid && rdy && !r) begin
            check("order", {16'd0, s_data}, {16'd0, exp_word});
            exp_word = exp_word + 16'd1;
            xfers++;
        end
        if (en) begin
            if (s_ren && q.size() > 0) begin
                fv = 1'b1;
                fd = q.pop_front();
            end else begin
                fv = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        q.delete();
        fv = 1'b0;
        xfers = 0;
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
    endtask

    task automatic load(input logic [15:0] first, input int n);
        for (int k = 0; k < n; k++) begin
            q.push_back(first + 16'(k));
        end
    endtask

    initial begin
        bus_if.out_ready = 1'b0;
        bus_if.mem_valid = 1'b0;
        bus_if.mem_data  = 16'h0000;

        // Reset state
        do_reset();
        check("rst_out_valid", {31'd0, s_valid}, 32'd0);
        check("rst_occupancy", {30'd0, s_occ}, 32'd0);
        check("rst_resp_err", {31'd0, s_err}, 32'd0);

        // 1: full-rate streaming of 0x0001..0x0008
        load(16'h0001, 8);
        exp_word = 16'h0001;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b0);
            check("t1_mem_ren", {31'd0, s_ren}, 32'd1);
            check("t1_occ_le1", {31'd0, (s_occ <= 2'd1)}, 32'd1);
            if (i >= 2 && i <= 9) begin
                check("t1_valid", {31'd0, s_valid}, 32'd1);
                check("t1_data", {16'd0, s_data}, 32'(i - 1));
            end
        end
        check("t1_xfers", 32'(xfers), 32'd8);
        check("t1_resp_err", {31'd0, s_err}, 32'd0);

        // 2: back-pressure for 6 cycles, then release
        do_reset();
        load(16'h0001, 8);
        exp_word = 16'h0001;
        ren_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (s_ren) ren_cnt++;
        end
        check("t2_ren_count", 32'(ren_cnt), 32'd2);
        check("t2_occ_full", {30'd0, s_occ}, 32'd2);
        check("t2_hold_data", {16'd0, s_data}, 32'h0001);
        for (int i = 6; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (i <= 13) begin
                check("t2_valid", {31'd0, s_valid}, 32'd1);
                check("t2_data", {16'd0, s_data}, 32'(i - 5));
            end
        end
        check("t2_xfers", 32'(xfers), 32'd8);

        // 3: empty FIFO, then a single word 0x00AA
        do_reset();
        exp_word = 16'h00AA;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0);
            check("t3_empty_occ", {30'd0, s_occ}, 32'd0);
            check("t3_empty_ren", {31'd0, s_ren}, 32'd1);
        end
        q.push_back(16'h00AA);
        for (int j = 0; j < 6; j++) begin
            step(1'b1, 1'b1, 1'b0);
            if (j < 2) check("t3_occ_pre", {30'd0, s_occ}, 32'd0);
            if (j == 2) check("t3_data", {15'd0, s_valid, s_data}, 32'h1_00AA);
            if (j > 2) check("t3_valid_post", {31'd0, s_valid}, 32'd0);
        end
        check("t3_xfers", 32'(xfers), 32'd1);
        check("t3_resp_err", {31'd0, s_err}, 32'd0);

        // 4: clk_en toggling during streaming
        do_reset();
        load(16'h0001, 8);
        exp_word = 16'h0001;
        prev_en0 = 1'b0;
        occ_held = 2'd0;
        for (int i = 0; i < 24; i++) begin
            step((i >= 8) || (i % 2 == 0), 1'b1, 1'b0);
            if (prev_en0) check("t4_frozen_occ", {30'd0, s_occ}, {30'd0, occ_held});
            prev_en0 = (i < 8) && (i % 2 == 1);
            occ_held = s_occ;
        end
        check("t4_xfers", 32'(xfers), 32'd8);
        check("t4_last_word", {16'd0, exp_word}, 32'h0009);

        // 5: stray response while nothing is in flight
        do_reset();
        q.push_back(16'h0055);
        exp_word = 16'h0055;
        force_v = 1'b1;
        force_d = 16'h1234;
        step(1'b1, 1'b1, 1'b0);
        check("t5_err_before", {31'd0, s_err}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0);
            check("t5_err_sticky", {31'd0, s_err}, 32'd1);
        end
        check("t5_xfers", 32'(xfers), 32'd1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        check("t5_err_cleared", {31'd0, s_err}, 32'd0);

        // 6: reset with a full skid buffer and a response landing
        do_reset();
        load(16'h0001, 8);
        exp_word = 16'h0001;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
        end
        check("t6_occ_before", {30'd0, s_occ}, 32'd2);
        force_v = 1'b1;
        force_d = 16'hBEEF;
        step(1'b1, 1'b0, 1'b1);
        q.delete();
        load(16'h0010, 4);
        exp_word = 16'h0010;
        xfers = 0;
        for (int j = 0; j < 8; j++) begin
            step(1'b1, 1'b1, 1'b0);
            if (j == 0) begin
                check("t6_occ_after", {30'd0, s_occ}, 32'd0);
                check("t6_valid_after", {31'd0, s_valid}, 32'd0);
                check("t6_err_after", {31'd0, s_err}, 32'd0);
            end
            if (j == 2) check("t6_restart", {15'd0, s_valid, s_data}, 32'h1_0010);
        end
        check("t6_xfers", 32'(xfers), 32'd4);
        check("t6_resp_err", {31'd0, s_err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
